// File: rtl/ipg_arb_pkg.sv
// ---------------------------------------------------------------------------
// ipg_arb_pkg
// Shared constants and types for the IPG-aware TX arbiter.
//   - Sync header codes (control vs. data blocks).
//   - The two control blocks the arbiter can generate on its own:
//     IDLE_BLOCK (type 0x1e, all control codes idle) and ERROR_BLOCK
//     (type 0x1e, all eight 7-bit control codes set to the error code 0x1e).
//   - Arbiter FSM state encoding.
//   - Helper that turns an inter-frame gap in bytes into 64-bit block cycles.
// ---------------------------------------------------------------------------
package ipg_arb_pkg;

    // Sync headers as an enum so both codes live together even though the
    // arbiter itself only ever generates the control header.
    typedef enum logic [1:0] {
        SYNC_CTRL = 2'b01,
        SYNC_DATA = 2'b10
    } sync_hdr_e;

    localparam logic [63:0] IDLE_BLOCK  = 64'h000000000000001e;
    localparam logic [63:0] ERROR_BLOCK = {{8{7'h1e}}, 8'h1e};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_GAP,
        ST_REQ
    } arb_state_e;

    // Widest gap is (255+7)>>3 = 32 block cycles, which fits in 6 bits.
    localparam int GAP_CNT_W = 6;

    // Round the byte gap up to whole 8-byte blocks.
    function automatic logic [GAP_CNT_W-1:0] ifg_to_gap_cycles(input logic [7:0] ifg_bytes);
        logic [8:0] rounded;
        rounded = {1'b0, ifg_bytes} + 9'd7;
        return rounded[8:3];
    endfunction

endpackage

// File: rtl/ipg_arb_gap_counter.sv
// ---------------------------------------------------------------------------
// ipg_arb_gap_counter
// Inter-frame gap down-counter. Holds its value unless told to load or
// decrement, which is how the arbiter freezes the gap while a request
// message borrows the idle time.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   load_i         - load load_val_i (takes priority over dec_i)
//   load_val_i     - gap length in block cycles
//   dec_i          - count down by one (saturates at zero)
//   cnt_o          - current remaining gap
//   zero_o         - remaining gap is zero
// ---------------------------------------------------------------------------
module ipg_arb_gap_counter
    import ipg_arb_pkg::*;
#(
    parameter int CNT_W = GAP_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over decrement; with neither asserted the count is frozen.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ipg_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ipg_tx_arbiter
// Merges MAC frame blocks and RREQ/WREQ message blocks onto one 64b/66b-style
// PHY TX stream. Grants are message-atomic, the inter-frame gap after each
// MAC frame is enforced in whole block cycles, and request messages may be
// slipped into that gap (the gap count is frozen while they run).
// All serdes outputs are registered: an accepted beat shows up exactly one
// cycle after its valid&ready cycle.
//
// Ports:
//   tx_clk, tx_rst_n          - clock, asynchronous active-low reset
//   ifg_delay                 - inter-frame gap in bytes
//   mac_blk_*                 - MAC frame block stream (valid/ready/last)
//   req_blk_*                 - request message block stream (valid/ready/last)
//   serdes_tx_data/hdr        - block to the PHY TX
//   mac_underflow             - one-cycle pulse when a MAC frame stalls mid-frame
//   req_msg_count             - wrapping count of completed request messages
//
// Configuration macro:
//   IPG_ARB_STARVE_BOOST_EN   - adds a starvation counter; once a request has
//                               waited STARVE_CYCLES cycles it beats the MAC in
//                               the IDLE arbitration.
// ---------------------------------------------------------------------------
module ipg_tx_arbiter
    import ipg_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int HDR_WIDTH     = 2,
    parameter int STARVE_CYCLES = 32
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst_n,
    input  logic [7:0]            ifg_delay,
    input  logic [DATA_WIDTH-1:0] mac_blk_data,
    input  logic [HDR_WIDTH-1:0]  mac_blk_hdr,
    input  logic                  mac_blk_valid,
    input  logic                  mac_blk_last,
    output logic                  mac_blk_ready,
    input  logic [DATA_WIDTH-1:0] req_blk_data,
    input  logic [HDR_WIDTH-1:0]  req_blk_hdr,
    input  logic                  req_blk_valid,
    input  logic                  req_blk_last,
    output logic                  req_blk_ready,
    output logic [DATA_WIDTH-1:0] serdes_tx_data,
    output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
    output logic                  mac_underflow,
    output logic [15:0]           req_msg_count
);

    localparam logic [DATA_WIDTH-1:0] IDLE_DATA  = DATA_WIDTH'(IDLE_BLOCK);
    localparam logic [DATA_WIDTH-1:0] ERROR_DATA = DATA_WIDTH'(ERROR_BLOCK);
    localparam logic [HDR_WIDTH-1:0]  CTRL_HDR   = HDR_WIDTH'(SYNC_CTRL);

    arb_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [HDR_WIDTH-1:0]  tx_hdr_q, tx_hdr_d;
    logic                  underflow_q, underflow_d;
    logic [15:0]           msg_count_q, msg_count_d;

    logic                  mac_grant;
    logic                  req_grant;
    logic                  mac_accept;
    logic                  req_accept;
    logic                  req_boost;

    logic                  gap_load;
    logic                  gap_dec;
    logic [GAP_CNT_W-1:0]  gap_load_val;
    logic [GAP_CNT_W-1:0]  gap_cnt;
    logic                  gap_zero;

    assign gap_load_val = ifg_to_gap_cycles(ifg_delay);

    ipg_arb_gap_counter #(
        .CNT_W (GAP_CNT_W)
    ) u_gap_counter (
        .clk_i      (tx_clk),
        .rst_ni     (tx_rst_n),
        .load_i     (gap_load),
        .load_val_i (gap_load_val),
        .dec_i      (gap_dec),
        .cnt_o      (gap_cnt),
        .zero_o     (gap_zero)
    );

`ifdef IPG_ARB_STARVE_BOOST_EN
    localparam int STARVE_W = ($clog2(STARVE_CYCLES + 1) > 6) ? $clog2(STARVE_CYCLES + 1) : 6;
    localparam logic [STARVE_W-1:0] STARVE_TH = STARVE_W'(STARVE_CYCLES);

    logic [STARVE_W-1:0] starve_q, starve_d;

    // Counts cycles a request sits valid without being granted; saturates so
    // a long MAC burst cannot wrap it back below the threshold.
    always_comb begin
        starve_d = starve_q;
        if (req_grant) begin
            starve_d = '0;
        end else if (req_blk_valid && (starve_q != '1)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign req_boost = (starve_q >= STARVE_TH);
`else
    // STARVE_CYCLES only matters with the boost compiled in.
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_CYCLES > 0);
    assign req_boost         = 1'b0;
`endif

    // Arbitration, next state and the block to register for the next cycle.
    // Grants are decided combinationally so an IDLE or GAP cycle that grants
    // a requester already accepts its first beat.
    always_comb begin
        state_d     = state_q;
        mac_grant   = 1'b0;
        req_grant   = 1'b0;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;
        tx_data_d   = IDLE_DATA;
        tx_hdr_d    = CTRL_HDR;
        underflow_d = 1'b0;
        msg_count_d = msg_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mac_blk_valid && !(req_boost && req_blk_valid)) begin
                    mac_grant = 1'b1;
                end else if (req_blk_valid) begin
                    req_grant = 1'b1;
                end
            end
            ST_MAC: mac_grant = 1'b1;
            ST_GAP: req_grant = req_blk_valid;
            ST_REQ: req_grant = 1'b1;
            default: ;
        endcase

        mac_accept = mac_grant && mac_blk_valid;
        req_accept = req_grant && req_blk_valid;

        if (mac_accept) begin
            tx_data_d = mac_blk_data;
            tx_hdr_d  = mac_blk_hdr;
            if (mac_blk_last) begin
                gap_load = 1'b1;
                state_d  = (gap_load_val == '0) ? ST_IDLE : ST_GAP;
            end else begin
                state_d = ST_MAC;
            end
        end else if (req_accept) begin
            tx_data_d = req_blk_data;
            tx_hdr_d  = req_blk_hdr;
            if (req_blk_last) begin
                msg_count_d = msg_count_q + 16'd1;
                // A zero gap count means the message did not start in a gap.
                state_d     = gap_zero ? ST_IDLE : ST_GAP;
            end else begin
                state_d = ST_REQ;
            end
        end else if (state_q == ST_MAC) begin
            tx_data_d   = ERROR_DATA;
            underflow_d = 1'b1;
        end else if (state_q == ST_GAP) begin
            gap_dec = 1'b1;
            if (gap_cnt <= GAP_CNT_W'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= IDLE_DATA;
            tx_hdr_q    <= CTRL_HDR;
            underflow_q <= 1'b0;
            msg_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_hdr_q    <= tx_hdr_d;
            underflow_q <= underflow_d;
            msg_count_q <= msg_count_d;
        end
    end

    // Readies are forced low while reset is held, even if a source is valid.
    assign mac_blk_ready  = mac_grant && tx_rst_n;
    assign req_blk_ready  = req_grant && tx_rst_n;
    assign serdes_tx_data = tx_data_q;
    assign serdes_tx_hdr  = tx_hdr_q;
    assign mac_underflow  = underflow_q;
    assign req_msg_count  = msg_count_q;

endmodule

// File: tb/tb_ipg_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ipg_tx_arbiter
// Drives MAC frames and request messages from beat queues and checks every
// cycle against a transaction-level model of the arbitration rules: who owns
// the link, how many idle gap cycles are still owed, and how long a request
// has been waiting.
// ---------------------------------------------------------------------------
module tb_ipg_tx_arbiter;

    localparam int DW = 64;
    localparam int HW = 2;
`ifdef IPG_ARB_STARVE_BOOST_EN
    localparam int STARVE = 4;
    localparam bit BOOST  = 1'b1;
`else
    localparam int STARVE = 32;
    localparam bit BOOST  = 1'b0;
`endif

    localparam logic [63:0] IDLE_BLK = 64'h000000000000001e;
    localparam logic [1:0]  HDR_CTRL = 2'b01;
    localparam logic [1:0]  HDR_DATA = 2'b10;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hdr;
        logic        last;
        int          preGap;
    } beat_t;

    logic          tx_clk;
    logic          tx_rst_n;
    logic [7:0]    ifg_delay;
    logic [DW-1:0] mac_blk_data;
    logic [HW-1:0] mac_blk_hdr;
    logic          mac_blk_valid;
    logic          mac_blk_last;
    logic          mac_blk_ready;
    logic [DW-1:0] req_blk_data;
    logic [HW-1:0] req_blk_hdr;
    logic          req_blk_valid;
    logic          req_blk_last;
    logic          req_blk_ready;
    logic [DW-1:0] serdes_tx_data;
    logic [HW-1:0] serdes_tx_hdr;
    logic          mac_underflow;
    logic [15:0]   req_msg_count;

    beat_t       macQ[$];
    beat_t       reqQ[$];
    logic [63:0] errBlk;

    // Reference model: owner 0 = nobody, 1 = MAC frame open, 2 = request open.
    int          owner;
    int          gapLeft;
    int          starve;
    logic [15:0] expCount;

    int nCompared;
    int nMismatch;
    int seenErr;
    int seenUf;

    ipg_tx_arbiter #(
        .DATA_WIDTH    (DW),
        .HDR_WIDTH     (HW),
        .STARVE_CYCLES (STARVE)
    ) dut (
        .tx_clk         (tx_clk),
        .tx_rst_n       (tx_rst_n),
        .ifg_delay      (ifg_delay),
        .mac_blk_data   (mac_blk_data),
        .mac_blk_hdr    (mac_blk_hdr),
        .mac_blk_valid  (mac_blk_valid),
        .mac_blk_last   (mac_blk_last),
        .mac_blk_ready  (mac_blk_ready),
        .req_blk_data   (req_blk_data),
        .req_blk_hdr    (req_blk_hdr),
        .req_blk_valid  (req_blk_valid),
        .req_blk_last   (req_blk_last),
        .req_blk_ready  (req_blk_ready),
        .serdes_tx_data (serdes_tx_data),
        .serdes_tx_hdr  (serdes_tx_hdr),
        .mac_underflow  (mac_underflow),
        .req_msg_count  (req_msg_count)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pushFrame(input bit toReq, input int n, input logic [63:0] first,
                             input logic [63:0] step, input bit rnd, input int firstGap,
                             input int stallAt, input int stallLen);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = rnd ? {$urandom, $urandom} : first + step * 64'(i);
            b.hdr  = rnd ? 2'($urandom) : HDR_DATA;
            b.last = (i == n - 1);
            if (i == 0)                                  b.preGap = firstGap;
            else if (i == stallAt)                       b.preGap = stallLen;
            else if (rnd && $urandom_range(0, 9) == 0)   b.preGap = $urandom_range(1, 3);
            else                                         b.preGap = 0;
            if (toReq) reqQ.push_back(b);
            else       macQ.push_back(b);
        end
    endtask

    // One clock cycle: drive sources at the falling edge, check readies,
    // then check the registered outputs just after the rising edge.
    task automatic applyStimulus();
        bit          mv, rv, expMacRdy, expReqRdy, expUf;
        beat_t       mb, rb;
        logic [63:0] expData;
        logic [1:0]  expHdr;

        mv = (macQ.size() > 0) && (macQ[0].preGap == 0);
        rv = (reqQ.size() > 0) && (reqQ[0].preGap == 0);
        if (mv) mb = macQ[0];
        if (rv) rb = reqQ[0];

        mac_blk_valid = mv;
        mac_blk_data  = mv ? mb.data : {$urandom, $urandom};
        mac_blk_hdr   = mv ? mb.hdr : 2'($urandom);
        mac_blk_last  = mv ? mb.last : 1'($urandom);
        req_blk_valid = rv;
        req_blk_data  = rv ? rb.data : {$urandom, $urandom};
        req_blk_hdr   = rv ? rb.hdr : 2'($urandom);
        req_blk_last  = rv ? rb.last : 1'($urandom);

        expMacRdy = 1'b0;
        expReqRdy = 1'b0;
        if (owner == 1)                                    expMacRdy = 1'b1;
        else if (owner == 2)                               expReqRdy = 1'b1;
        else if (gapLeft > 0)                              expReqRdy = rv;
        else if (mv && !(BOOST && rv && starve >= STARVE)) expMacRdy = 1'b1;
        else if (rv)                                       expReqRdy = 1'b1;

        #1;
        checkOutput("mac_ready", mac_blk_ready, expMacRdy);
        checkOutput("req_ready", req_blk_ready, expReqRdy);

        expData = IDLE_BLK;
        expHdr  = HDR_CTRL;
        expUf   = 1'b0;
        if (expMacRdy && mv) begin
            expData = mb.data;
            expHdr  = mb.hdr;
            void'(macQ.pop_front());
            if (mb.last) begin
                owner   = 0;
                gapLeft = (int'(ifg_delay) + 7) / 8;
            end else begin
                owner = 1;
            end
        end else if (expReqRdy && rv) begin
            expData = rb.data;
            expHdr  = rb.hdr;
            void'(reqQ.pop_front());
            if (rb.last) begin
                owner    = 0;
                expCount = expCount + 16'd1;
            end else begin
                owner = 2;
            end
        end else if (owner == 1) begin
            expData = errBlk;
            expUf   = 1'b1;
        end else if (owner == 0 && gapLeft > 0) begin
            gapLeft--;
        end

        if (expReqRdy)  starve = 0;
        else if (rv)    starve++;

        if (!mv && macQ.size() > 0 && macQ[0].preGap > 0) macQ[0].preGap = macQ[0].preGap - 1;
        if (!rv && reqQ.size() > 0 && reqQ[0].preGap > 0) reqQ[0].preGap = reqQ[0].preGap - 1;

        @(posedge tx_clk);
        #1;
        checkOutput("tx_data", serdes_tx_data, expData);
        checkOutput("tx_hdr", serdes_tx_hdr, expHdr);
        checkOutput("underflow", mac_underflow, expUf);
        checkOutput("msg_count", req_msg_count, expCount);
        if (serdes_tx_data === errBlk && serdes_tx_hdr === HDR_CTRL) seenErr++;
        if (mac_underflow === 1'b1) seenUf++;
        @(negedge tx_clk);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic drain(input int budget);
        int  cycles;
        bit  timedOut;
        cycles = 0;
        while ((macQ.size() > 0 || reqQ.size() > 0 || owner != 0 || gapLeft > 0) && cycles < budget) begin
            applyStimulus();
            cycles++;
        end
        timedOut = (cycles >= budget);
        checkOutput("drain_timeout", timedOut, 1'b0);
    endtask

    // Asynchronous reset while sources still assert valid: readies must drop.
    task automatic doReset();
        tx_rst_n      = 1'b0;
        mac_blk_valid = 1'b1;
        req_blk_valid = 1'b1;
        #1;
        checkOutput("rst_data", serdes_tx_data, IDLE_BLK);
        checkOutput("rst_hdr", serdes_tx_hdr, HDR_CTRL);
        checkOutput("rst_mac_ready", mac_blk_ready, 1'b0);
        checkOutput("rst_req_ready", req_blk_ready, 1'b0);
        checkOutput("rst_underflow", mac_underflow, 1'b0);
        checkOutput("rst_count", req_msg_count, 16'd0);
        macQ.delete();
        reqQ.delete();
        owner    = 0;
        gapLeft  = 0;
        starve   = 0;
        expCount = 16'd0;
        @(negedge tx_clk);
        @(negedge tx_clk);
        tx_rst_n = 1'b1;
    endtask

    initial begin
        nCompared = 0;
        nMismatch = 0;
        seenErr   = 0;
        seenUf    = 0;
        errBlk    = 64'h1e;
        for (int i = 0; i < 8; i++) errBlk[8 + 7 * i +: 7] = 7'h1e;

        tx_rst_n      = 1'b0;
        ifg_delay     = 8'd12;
        mac_blk_valid = 1'b0;
        mac_blk_data  = '0;
        mac_blk_hdr   = '0;
        mac_blk_last  = 1'b0;
        req_blk_valid = 1'b0;
        req_blk_data  = '0;
        req_blk_hdr   = '0;
        req_blk_last  = 1'b0;

        $display("[TB] start, STARVE=%0d", STARVE);
        @(negedge tx_clk);
        doReset();

        // Idle link: control idle blocks only.
        runCycles(10);

        // 8-beat frame (1..8) then a second frame; gap of 12 bytes = 2 cycles.
        pushFrame(1'b0, 8, 64'd1, 64'd1, 1'b0, 0, -1, 0);
        pushFrame(1'b0, 4, 64'h101, 64'd1, 1'b0, 0, -1, 0);
        drain(200);

        // Request message arriving during the frame fills the gap.
        doReset();
        pushFrame(1'b0, 8, 64'd1, 64'd1, 1'b0, 0, -1, 0);
        pushFrame(1'b1, 3, 64'h0a, 64'h10, 1'b0, 4, -1, 0);
        pushFrame(1'b0, 2, 64'h201, 64'd1, 1'b0, 0, -1, 0);
        drain(200);
        checkOutput("count_after_gap_req", req_msg_count, 16'd1);

        // Simultaneous valids in IDLE: MAC first, request in the gap.
        pushFrame(1'b0, 3, 64'h301, 64'd1, 1'b0, 0, -1, 0);
        pushFrame(1'b1, 2, 64'h401, 64'd1, 1'b0, 0, -1, 0);
        drain(200);

        // Two-cycle mid-frame stall.
        seenErr = 0;
        seenUf  = 0;
        pushFrame(1'b0, 6, 64'h501, 64'd1, 1'b0, 0, 3, 2);
        drain(200);
        checkOutput("stall_error_blocks", 64'(seenErr), 64'd2);
        checkOutput("stall_underflows", 64'(seenUf), 64'd2);

        // Reset in the middle of a frame, then idle.
        pushFrame(1'b0, 8, 64'h601, 64'd1, 1'b0, 0, -1, 0);
        runCycles(4);
        doReset();
        runCycles(3);

        // Zero gap: frames go back to back.
        ifg_delay = 8'd0;
        pushFrame(1'b0, 2, 64'h701, 64'd1, 1'b0, 0, -1, 0);
        pushFrame(1'b0, 2, 64'h801, 64'd1, 1'b0, 0, -1, 0);
        drain(200);

`ifdef IPG_ARB_STARVE_BOOST_EN
        // Back-to-back frames with a request waiting the whole time.
        pushFrame(1'b0, 4, 64'h901, 64'd1, 1'b0, 0, -1, 0);
        pushFrame(1'b0, 4, 64'ha01, 64'd1, 1'b0, 0, -1, 0);
        pushFrame(1'b0, 4, 64'hb01, 64'd1, 1'b0, 0, -1, 0);
        pushFrame(1'b1, 1, 64'hc01, 64'd1, 1'b0, 0, -1, 0);
        drain(200);
`endif

        // Randomised traffic with stalls, varying gaps and random headers.
        ifg_delay = 8'd12;
        for (int i = 0; i < 1500; i++) begin
            if (macQ.size() < 12 && $urandom_range(0, 9) == 0)
                pushFrame(1'b0, $urandom_range(1, 8), 64'd0, 64'd0, 1'b1, $urandom_range(0, 3), -1, 0);
            if (reqQ.size() < 12 && $urandom_range(0, 11) == 0)
                pushFrame(1'b1, $urandom_range(1, 4), 64'd0, 64'd0, 1'b1, $urandom_range(0, 3), -1, 0);
            if ($urandom_range(0, 49) == 0)
                ifg_delay = ($urandom_range(0, 9) == 0) ? 8'hff : 8'($urandom_range(0, 24));
            applyStimulus();
        end
        drain(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/ipg_tx_arbiter.md
IPG_TX_ARBITER -- requirements
Module: ipg_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, block payload width.
REQ-002 Parameter HDR_WIDTH, default 2, sync header width.
REQ-003 Parameter STARVE_CYCLES, default 32, request-pending cycles before a priority boost (used only under the configuration macro).
REQ-004 Ports:
- tx_clk in 1: the single clock.
- tx_rst_n in 1: asynchronous, active-low reset.
- ifg_delay in 8: inter-frame gap in bytes.
- mac_blk_data in DATA_WIDTH, mac_blk_hdr in HDR_WIDTH, mac_blk_valid in 1, mac_blk_last in 1: MAC frame blocks.
- mac_blk_ready out 1: MAC beat accepted.
- req_blk_data in DATA_WIDTH, req_blk_hdr in HDR_WIDTH, req_blk_valid in 1, req_blk_last in 1: RREQ/WREQ message blocks.
- req_blk_ready out 1: request beat accepted.
- serdes_tx_data out DATA_WIDTH, serdes_tx_hdr out HDR_WIDTH: blocks to the PHY TX.
- mac_underflow out 1: one-cycle pulse on a mid-frame MAC stall.
- req_msg_count out 16: count of completed request messages.

Function
REQ-005 The outputs SHALL be registered; an accepted beat appears on serdes_tx_* exactly 1 cycle after its valid&ready cycle.
REQ-006 The FSM states SHALL be IDLE, MAC, GAP and REQ.
REQ-007 IDLE: if mac_blk_valid, go to MAC; otherwise, if req_blk_valid, go to REQ; otherwise emit IDLE_BLOCK. The decision is combinational and takes effect in the same cycle.
REQ-008 The ready signals SHALL be asserted only for the granted requester, and only in MAC or REQ state, or in the IDLE cycle that grants it; both readies SHALL never be high together.
REQ-009 Grants SHALL be message-atomic: MAC holds until the beat with mac_blk_last; REQ holds until the beat with req_blk_last.
REQ-010 MAC, when the last beat is accepted, SHALL go to GAP and load gap_cnt = (ifg_delay+7)>>3; ifg_delay=0 goes straight to IDLE.
REQ-011 GAP SHALL decrement gap_cnt once per cycle and emit IDLE_BLOCK. A MAC grant SHALL be forbidden in GAP. If req_blk_valid, a REQ grant SHALL occur, with gap_cnt frozen during REQ; return to GAP when the message ends, or to IDLE when gap_cnt=0.
REQ-012 REQ entered from IDLE SHALL return to IDLE at message end.
REQ-013 MAC with valid low mid-frame SHALL emit ERROR_BLOCK, pulse mac_underflow and stay in MAC.
REQ-014 REQ with valid low mid-message SHALL emit IDLE_BLOCK and stay in REQ; no error is flagged.
REQ-015 req_msg_count SHALL increment on each accepted req last beat and wrap from 0xFFFF to 0.
REQ-016 Accepted blocks SHALL pass through unmodified, data and hdr.
REQ-017 When IDLE sees mac valid and req valid simultaneously, MAC SHALL win (unless REQ-021 applies).

Reset
REQ-018 While tx_rst_n=0, asynchronously:
- state=IDLE; gap_cnt=0, starve counter=0, req_msg_count=0.
- serdes_tx_data=IDLE_BLOCK data, serdes_tx_hdr=SYNC_CTRL.
- both readies=0, mac_underflow=0.
REQ-019 Reset asserted mid-message SHALL abort the message; after deassertion the first block SHALL be IDLE_BLOCK.

Configuration
REQ-020 Macro IPG_ARB_STARVE_BOOST_EN SHALL compile in the starvation-boost feature.
REQ-021 With the macro defined:
- a 6-bit-minimum counter increments each cycle that req_blk_valid=1 without a REQ grant, and clears on a REQ grant.
- at count >= STARVE_CYCLES, REQ wins the IDLE arbitration over MAC.
REQ-022 Without the macro, the counter SHALL not exist and REQ-017 priority SHALL always apply.

Structure
REQ-023 Package ipg_arb_pkg SHALL hold:
- SYNC_DATA=2'b10, SYNC_CTRL=2'b01.
- IDLE_BLOCK=64'h000000000000001e.
- ERROR_BLOCK: type 0x1e, all eight control codes 7'h1e.
- the FSM state enum.
REQ-024 One sub-module, ipg_arb_gap_counter (load/decrement/freeze/zero flag), is natural; all else stays flat.

Verification
REQ-025 Idle bench (no valids, 10 cycles) -> serdes_tx_data=64'h1e, hdr=2'b01 every cycle; both readies 0.
REQ-026 8-beat MAC frame (data 1..8), ifg_delay=12 -> outputs 1..8 with 1-cycle latency, then 2 IDLE_BLOCK cycles before the next MAC grant.
REQ-027 3-beat request message (0x...0a, 0x...1a, 0x...2a) valid during GAP -> emitted right after the MAC frame; req_msg_count=1; MAC held off until the gap completes.
REQ-028 mac valid and req valid asserted in the same IDLE cycle -> MAC granted first, REQ granted after the gap.
REQ-029 MAC valid dropped for 2 cycles mid-frame -> 2 ERROR_BLOCK outputs and 2 mac_underflow pulses; the frame then resumes.
REQ-030 With IPG_ARB_STARVE_BOOST_EN: back-to-back MAC frames plus constant req valid, STARVE_CYCLES=4 -> REQ wins the first IDLE arbitration after the count reaches 4.
